// File: rtl/lcd_text_driver.sv
// HD44780-style 8-bit character LCD driver: power-up wait, init commands, then
// full-screen refreshes from a text snapshot. Define LCD_HEX_DECODE_EN to show hex digits.
module lcd_text_driver #(
  parameter int DIV           = 50000,
  parameter int CHARS         = 32,
  parameter int POWERUP_TICKS = 20,
  parameter int CLEAR_TICKS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic [CHARS*8-1:0] text,
  output logic               busy,
  output logic               done,
  output logic               E,
  output logic               RW,
  output logic               RS,
  output logic [7:0]         lcd
);

  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W    = $clog2(CHARS);
  localparam int WAIT_MAX = (POWERUP_TICKS > CLEAR_TICKS) ? POWERUP_TICKS : CLEAR_TICKS;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'((POWERUP_TICKS > 0) ? POWERUP_TICKS - 1 : 0);
  localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'((CLEAR_TICKS > 0) ? CLEAR_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0]  INIT_WAIT = IDX_W'(4);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CHARS - 1);
  localparam logic [IDX_W-1:0]  IDX_LINE1 = IDX_W'(15);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHAR, FIN} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CHARS*8-1:0] snap_q;
  logic               tick, writing, byte_end, accept;
  logic [7:0]         char_raw;

  function automatic logic [7:0] init_cmd(input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] to_ascii(input logic [7:0] b);
`ifdef LCD_HEX_DECODE_EN
    if (b[3:0] < 4'd10) return 8'h30 + {4'h0, b[3:0]};
    else                return 8'h37 + {4'h0, b[3:0]};
`else
    return b;
`endif
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign writing  = ((state_q == INIT) && (idx_q < INIT_WAIT)) ||
                    (state_q == ADDR) || (state_q == CHAR);
  assign byte_end = tick && (phase_q == PH_HOLD);
  assign accept   = (state_q == IDLE) && update;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWRUP;
      phase_q <= PH_SETUP;
      div_q   <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: the snapshot is pure data gated by accept, so it needs no reset and stays a plain register bank.
  always_ff @(posedge clk) begin
    if (accept) snap_q <= text;
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);

    if (writing && tick)
      phase_d = (phase_q == PH_HOLD) ? PH_SETUP : phase_e'(phase_q + 2'd1);

    case (state_q)
      PWRUP: begin
        if ((POWERUP_TICKS == 0) || (tick && (wait_q == PWR_LAST))) begin
          state_d = INIT;
          wait_d  = '0;
        end else if (tick) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      INIT: begin
        if (idx_q != INIT_WAIT) begin
          if (byte_end) begin
            idx_d = idx_q + IDX_W'(1);
            if ((idx_q == IDX_W'(3)) && (CLEAR_TICKS == 0)) begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
        end else if (tick) begin
          if (wait_q == CLR_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      IDLE: begin
        if (update) begin
          state_d = ADDR;
          phase_d = PH_SETUP;
          idx_d   = '0;
        end
      end
      ADDR: begin
        if (byte_end) state_d = CHAR;
      end
      CHAR: begin
        if (byte_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = FIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LINE1) state_d = ADDR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = PWRUP;
    endcase
  end

  always_comb begin
    char_raw = 8'h00;
    for (int i = 0; i < CHARS; i++)
      if (idx_q == IDX_W'(i)) char_raw = snap_q[8*i +: 8];
  end

  // E is decoded from async-reset flops, so rst drops the strobe without waiting for a clock.
  always_comb begin
    E   = 1'b0;
    RS  = 1'b0;
    lcd = 8'h00;
    case (state_q)
      INIT: begin
        if (idx_q < INIT_WAIT) begin
          lcd = init_cmd(idx_q[1:0]);
          E   = (phase_q == PH_STROBE);
        end
      end
      ADDR: begin
        lcd = (idx_q == '0) ? 8'h80 : 8'hC0;
        E   = (phase_q == PH_STROBE);
      end
      CHAR: begin
        RS  = 1'b1;
        lcd = to_ascii(char_raw);
        E   = (phase_q == PH_STROBE);
      end
      default: ;
    endcase
  end

  assign RW   = 1'b0;
  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver: a DIV=1 32-char instance and a DIV=4 16-char instance.
module tb_lcd_text_driver;

  logic         clk = 1'b0;
  logic         rst, update;
  logic [255:0] text;
  logic         busy, done, E, RW, RS;
  logic [7:0]   lcd;

  logic         rst4, update4;
  logic [127:0] text4;
  logic         busy4, done4, E4, RW4, RS4;
  logic [7:0]   lcd4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q[$];
  logic [8:0] q4[$];
  logic       e_prev  = 1'b0;
  logic       e4_prev = 1'b0;
  int         rw_bad  = 0;
  int         done_cnt  = 0;
  int         done_cnt4 = 0;

  always #5 clk = ~clk;

  lcd_text_driver #(.DIV(1), .CHARS(32), .POWERUP_TICKS(20), .CLEAR_TICKS(2)) dut (
    .clk(clk), .rst(rst), .update(update), .text(text),
    .busy(busy), .done(done), .E(E), .RW(RW), .RS(RS), .lcd(lcd)
  );

  lcd_text_driver #(.DIV(4), .CHARS(16), .POWERUP_TICKS(2), .CLEAR_TICKS(1)) dut4 (
    .clk(clk), .rst(rst4), .update(update4), .text(text4),
    .busy(busy4), .done(done4), .E(E4), .RW(RW4), .RS(RS4), .lcd(lcd4)
  );

  // Record every byte written ({RS, data}) on the rising edge of E.
  always @(negedge clk) begin
    if (E && !e_prev) q.push_back({RS, lcd});
    if (E4 && !e4_prev) q4.push_back({RS4, lcd4});
    e_prev  = E;
    e4_prev = E4;
    if (RW !== 1'b0 || RW4 !== 1'b0) rw_bad++;
    if (done === 1'b1) done_cnt++;
    if (done4 === 1'b1) done_cnt4++;
  end

  function automatic logic [7:0] enc(input logic [7:0] b);
`ifdef LCD_HEX_DECODE_EN
    return (b[3:0] < 4'd10) ? 8'h30 + {4'h0, b[3:0]} : 8'h37 + {4'h0, b[3:0]};
`else
    return b;
`endif
  endfunction

  function automatic logic [255:0] alpha_text();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
    return v;
  endfunction

  // Expected k-th byte of a 32-char refresh.
  function automatic logic [8:0] exp_byte(input logic [255:0] t, input int k);
    int c;
    if (k == 0)  return {1'b0, 8'h80};
    if (k == 17) return {1'b0, 8'hC0};
    c = (k < 17) ? k - 1 : k - 2;
    return {1'b1, enc(t[8*c +: 8])};
  endfunction

  function automatic logic [8:0] init_byte(input int k);
    case (k)
      0:       return 9'h038;
      1:       return 9'h00C;
      2:       return 9'h006;
      default: return 9'h001;
    endcase
  endfunction

  task automatic pulse_update();
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1; update = 1'b0; update4 = 1'b0; text = '0; text4 = '0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (E !== 1'b0)      begin n_fail++; $display("FAIL reset_E: got %b want 0", E); end
    if (RW !== 1'b0)     begin n_fail++; $display("FAIL reset_RW: got %b want 0", RW); end
    if (RS !== 1'b0)     begin n_fail++; $display("FAIL reset_RS: got %b want 0", RS); end
    if (lcd !== 8'h00)   begin n_fail++; $display("FAIL reset_lcd: got %h want 00", lcd); end
    if (busy !== 1'b1)   begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_init(input string tag);
    int n;
    q.delete();
    @(negedge clk) rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) break;
    end
    n_checks += 2;
    if (n < 33 || n > 35) begin n_fail++; $display("FAIL %s_busy_fall: got cycle %0d want 34", tag, n); end
    if (q.size() != 4)   begin n_fail++; $display("FAIL %s_count: got %0d bytes want 4", tag, q.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [8:0] got;
      got = (i < q.size()) ? q[i] : 9'h1FF;
      n_checks++;
      if (got !== init_byte(i)) begin n_fail++; $display("FAIL %s_cmd%0d: got %h want %h", tag, i, got, init_byte(i)); end
    end
  endtask

  task automatic test_refresh();
    int n;
    logic [255:0] t;
    t = alpha_text();
    text = t; q.delete(); done_cnt = 0;
    pulse_update();
    wait_idle(n);
    n_checks += 3;
    if (n != 103)       begin n_fail++; $display("FAIL refresh_busy_len: got %0d want 103", n); end
    if (done_cnt != 1)  begin n_fail++; $display("FAIL refresh_done: got %0d pulses want 1", done_cnt); end
    if (q.size() != 34) begin n_fail++; $display("FAIL refresh_count: got %0d want 34", q.size()); end
    for (int k = 0; k < 34; k++) begin
      logic [8:0] got;
      got = (k < q.size()) ? q[k] : 9'h1FF;
      n_checks++;
      if (got !== exp_byte(t, k)) begin n_fail++; $display("FAIL refresh_byte%0d: got %h want %h", k, got, exp_byte(t, k)); end
    end
  endtask

  task automatic test_ignore_update();
    int n;
    logic [255:0] t1;
    for (int i = 0; i < 32; i++) t1[8*i +: 8] = 8'(8'h20 + 3 * i);
    text = t1; q.delete(); done_cnt = 0;
    pulse_update();
    repeat (40) @(negedge clk);
    text = ~t1;
    pulse_update();
    wait_idle(n);
    repeat (10) @(negedge clk);
    n_checks += 3;
    if (done_cnt != 1)  begin n_fail++; $display("FAIL ignore_done: got %0d pulses want 1", done_cnt); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL ignore_queued: busy %b want 0", busy); end
    if (q.size() != 34) begin n_fail++; $display("FAIL ignore_count: got %0d want 34", q.size()); end
    for (int k = 0; k < 34; k++) begin
      logic [8:0] got;
      got = (k < q.size()) ? q[k] : 9'h1FF;
      n_checks++;
      if (got !== exp_byte(t1, k)) begin n_fail++; $display("FAIL ignore_byte%0d: got %h want %h", k, got, exp_byte(t1, k)); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [255:0] t;
    t = alpha_text();
    text = t; q.delete(); done_cnt = 0;
    @(negedge clk) update = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy %b want 0", busy); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy %b want 1", busy); end
    update = 1'b0;
    wait_idle(n);
    n_checks += 4;
    if (done_cnt != 2)  begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt); end
    if (q.size() != 68) begin n_fail++; $display("FAIL b2b_count: got %0d want 68", q.size()); end
    if (q.size() == 68) begin
      if (q[34] !== exp_byte(t, 0))  begin n_fail++; $display("FAIL b2b_first: got %h want %h", q[34], exp_byte(t, 0)); end
      if (q[67] !== exp_byte(t, 33)) begin n_fail++; $display("FAIL b2b_last: got %h want %h", q[67], exp_byte(t, 33)); end
    end else begin
      n_fail += 2; $display("FAIL b2b_bytes: got %0d bytes want 68", q.size());
    end
  endtask

  task automatic test_encoding();
    int n;
    logic [255:0] t;
    logic [7:0]   w0, w1;
    t = alpha_text();
    t[7:0] = 8'h0A; t[15:8] = 8'hF3;
`ifdef LCD_HEX_DECODE_EN
    w0 = 8'h41; w1 = 8'h33;
`else
    w0 = 8'h0A; w1 = 8'hF3;
`endif
    text = t; q.delete();
    pulse_update();
    wait_idle(n);
    n_checks += 2;
    if (q.size() < 3 || q[1] !== {1'b1, w0}) begin n_fail++; $display("FAIL enc_char0: got %h want %h", (q.size() > 1) ? q[1] : 9'h1FF, {1'b1, w0}); end
    if (q.size() < 3 || q[2] !== {1'b1, w1}) begin n_fail++; $display("FAIL enc_char1: got %h want %h", (q.size() > 2) ? q[2] : 9'h1FF, {1'b1, w1}); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [255:0] t;
    t = alpha_text();
    text = t; q.delete();
    pulse_update();
    n = 0;
    while (n < 200) begin
      @(negedge clk); #1;
      n++;
      if (q.size() >= 12) break;
    end
    n_checks += 2;
    if (q.size() < 12 || q[11] !== exp_byte(t, 11)) begin n_fail++; $display("FAIL mid_char10: got %0d bytes want char10 strobe", q.size()); end
    if (E !== 1'b1) begin n_fail++; $display("FAIL mid_strobe: E %b want 1", E); end
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (E !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_E: got %b want 0", E); end
    if (lcd !== 8'h00)  begin n_fail++; $display("FAIL mid_rst_lcd: got %h want 00", lcd); end
    if (busy !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_busy: got %b want 1", busy); end
    if (RS !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_RS: got %b want 0", RS); end
    if (done !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", done); end
    @(negedge clk);
    test_init("reinit");
  endtask

  task automatic test_div4();
    int n, w, gap;
    q4.delete();
    @(negedge clk) rst4 = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (busy4 === 1'b0) break;
    end
    n_checks += 2;
    if (n < 59 || n > 61) begin n_fail++; $display("FAIL div4_busy_fall: got cycle %0d want 60", n); end
    if (q4.size() != 4 || q4[0] !== 9'h038 || q4[3] !== 9'h001) begin n_fail++; $display("FAIL div4_init: got %0d bytes", q4.size()); end
    for (int i = 0; i < 16; i++) text4[8*i +: 8] = 8'(8'h61 + i);
    q4.delete(); done_cnt4 = 0;
    @(negedge clk) update4 = 1'b1;
    @(negedge clk) update4 = 1'b0;
    n = 0;
    while (E4 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    w = 0;
    while (E4 === 1'b1 && w < 20) begin w++; @(negedge clk); end
    gap = w;
    while (E4 !== 1'b1 && gap < 50) begin gap++; @(negedge clk); end
    n_checks += 2;
    if (w != 4)    begin n_fail++; $display("FAIL div4_e_width: got %0d want 4", w); end
    if (gap != 12) begin n_fail++; $display("FAIL div4_byte_period: got %0d want 12", gap); end
    n = 0;
    while (busy4 === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    n_checks += 4;
    if (q4.size() != 17) begin n_fail++; $display("FAIL div4_count: got %0d want 17", q4.size()); end
    if (q4.size() < 1 || q4[0] !== 9'h080) begin n_fail++; $display("FAIL div4_addr: got %0d bytes or wrong 0x80", q4.size()); end
    if (q4.size() != 17 || q4[16] !== {1'b1, enc(8'h70)}) begin n_fail++; $display("FAIL div4_last: got %h want %h", (q4.size() > 16) ? q4[16] : 9'h1FF, {1'b1, enc(8'h70)}); end
    if (done_cnt4 != 1)  begin n_fail++; $display("FAIL div4_done: got %0d want 1", done_cnt4); end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_refresh();
    test_ignore_update();
    test_back_to_back();
    test_encoding();
    test_reset_mid();
    test_div4();
    n_checks++;
    if (rw_bad != 0) begin n_fail++; $display("FAIL rw_low: got %0d cycles with RW!=0 want 0", rw_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_text_driver.md
LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

Interface
REQ-001 Parameter DIV, default 50000, clk cycles per LCD tick; legal range is 1 or more.
REQ-002 Parameter CHARS, default 32, number of displayed characters; legal values are 16 or 32.
REQ-003 Parameter POWERUP_TICKS, default 20, ticks waited after reset before the first command.
REQ-004 Parameter CLEAR_TICKS, default 2, extra ticks waited after the clear command (0x01).
REQ-005 Port clk, input, 1 bit, system clock; all state is clocked on the rising edge.
REQ-006 Port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-007 Port update, input, 1 bit, refresh request.
REQ-008 Port text, input, CHARS*8 bits, character buffer; character i is text[8i+7:8i].
REQ-009 Port busy, output, 1 bit, high while initialising or refreshing.
REQ-010 Port done, output, 1 bit, one-clk pulse at the end of each refresh.
REQ-011 Ports E, RW and RS, outputs, 1 bit each, LCD strobe, read/write select and register select.
REQ-012 Port lcd, output, 8 bits, LCD data bus.

Function
REQ-013 The internal tick SHALL be a one-clk enable asserted every DIV clk cycles; with DIV=1 it SHALL assert every cycle.
REQ-014 Every byte write SHALL take 3 ticks:
  - SETUP: E=0, RS and lcd valid.
  - STROBE: E=1.
  - HOLD: E=0, RS and lcd unchanged.
REQ-015 RW SHALL be 0 at all times.
REQ-016 FSM states SHALL be PWRUP, INIT, IDLE, ADDR, CHAR and FIN.
REQ-017 PWRUP SHALL wait POWERUP_TICKS ticks, then go to INIT.
REQ-018 INIT SHALL write, with RS=0, the commands 0x38, 0x0C, 0x06 and 0x01, in that order.
REQ-019 After 0x01, INIT SHALL wait CLEAR_TICKS ticks, then go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 In IDLE, update=1 on a clk edge SHALL latch the whole of text into a snapshot and go to ADDR on that edge.
REQ-022 update SHALL be ignored while busy=1; there is no queuing.
REQ-023 A text change after acceptance SHALL NOT affect the refresh in progress.
REQ-024 ADDR SHALL write, with RS=0, the command 0x80 before character 0.
REQ-025 When CHARS=32, ADDR SHALL also write, with RS=0, the command 0xC0 before character 16.
REQ-026 CHAR SHALL write characters 0 to 15 on line 1 with RS=1, then 16 to 31 on line 2 when CHARS=32.
REQ-027 Refresh length SHALL be 17 bytes (51 ticks) for CHARS=16 and 34 bytes (102 ticks) for CHARS=32.
REQ-028 After the final HOLD tick, the FSM SHALL enter FIN.
REQ-029 FIN SHALL assert done for exactly one clk cycle, then go to IDLE, with busy=0 from the next cycle.
REQ-030 If update=1 in the first IDLE cycle, it SHALL be accepted; back-to-back refreshes SHALL be legal.
REQ-031 The character index counter SHALL never exceed CHARS-1.
REQ-032 The tick counter SHALL wrap from DIV-1 to 0.

Reset
REQ-033 While rst=1, outputs SHALL be E=0, RW=0, RS=0, lcd=0x00, busy=1 and done=0.
REQ-034 While rst=1, the FSM SHALL be in PWRUP and the tick counter, phase counter, index counter and wait counter SHALL be 0.
REQ-035 rst asserted mid-refresh or mid-init SHALL abort immediately, with E=0 asynchronously.
REQ-036 After rst deasserts, the full PWRUP and INIT sequence SHALL repeat.

Configuration
REQ-037 The macro LCD_HEX_DECODE_EN SHALL select the character encoding.
REQ-038 With LCD_HEX_DECODE_EN defined, each character's low nibble SHALL map to ASCII: 0-9 to 0x30-0x39 and A-F to 0x41-0x46.
REQ-039 With LCD_HEX_DECODE_EN defined, the high nibble of each character SHALL be ignored.
REQ-040 Without LCD_HEX_DECODE_EN, snapshot bytes SHALL be driven raw as ASCII.
REQ-041 LCD_HEX_DECODE_EN SHALL NOT change timing or the interface.

Verification
REQ-042 DIV=1, POWERUP_TICKS=20, CLEAR_TICKS=2: release rst -> E pulses carry 0x38, 0x0C, 0x06, 0x01 with RS=0; busy falls at cycle 20+12+2=34 (one-cycle tolerance).
REQ-043 DIV=1, CHARS=32, text = ASCII "A" to "Z" then "012345", pulse update -> E strobes carry 0x80, 0x41 to 0x50, 0xC0, 0x51 to 0x5A, 0x30 to 0x35; done pulses once; busy is high for 103 cycles (102 ticks plus FIN).
REQ-044 Pulse update mid-refresh and change text after acceptance -> the strobe sequence is unchanged and done pulses once.
REQ-045 Assert rst during character 10 -> E=0, lcd=0x00 and busy=1 on the same cycle, then the init sequence repeats.
REQ-046 LCD_HEX_DECODE_EN defined, text bytes 0x0A and 0xF3 -> written bytes are 0x41 and 0x33.
REQ-047 DIV=4 -> E high width is exactly 4 clk cycles and consecutive ticks are 4 cycles apart.
